// File: rtl/aemb2_mdu_if.sv
// Operand/result bundle between the AEMB2 execute stage and the multiply/divide unit.
// The master drives the issue side; the slave (the MDU) returns the tagged result.
interface aemb2_mdu_if #(
  parameter int DW = 32
);
  logic          dena;
  logic          gpha;
  logic [5:0]    opc_of;
  logic [1:0]    imm_of;
  logic [DW-1:0] opa_of;
  logic [DW-1:0] opb_of;

  logic [DW-1:0] mdu_mx;
  logic          mdu_vld;
  logic          mdu_pha;
  logic          mdu_dz;
  logic          mdu_stall;

  modport master (
    output dena, gpha, opc_of, imm_of, opa_of, opb_of,
    input  mdu_mx, mdu_vld, mdu_pha, mdu_dz, mdu_stall
  );

  modport slave (
    input  dena, gpha, opc_of, imm_of, opa_of, opb_of,
    output mdu_mx, mdu_vld, mdu_pha, mdu_dz, mdu_stall
  );
endinterface

// File: rtl/aemb2_mdu.sv
// AEMB2 multiply/divide unit: dena-qualified multiply pipeline plus an iterative
// restoring divider that stalls the core; every result carries its thread phase.
module aemb2_mdu #(
  parameter int DW      = 32,
  parameter int MUL_EN  = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_EN  = 1
) (
  input  logic      gclk,
  input  logic      grst,
  aemb2_mdu_if.slave mdu
);

  localparam int         CW      = $clog2(DW);
  localparam logic [5:0] OPC_MUL = 6'h10;
  localparam logic [5:0] OPC_DIV = 6'h12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ITER,
    S_FIX,
    S_DONE
  } div_state_e;

  div_state_e    state_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] dsr_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q;
  logic          div_pha_q;
  logic          dz_q;

  logic          idle;
  logic          div_done;
  logic          adv;
  logic          mul_acc;
  logic          div_acc;
  logic          mul_fire;
  logic          last_vld;
  logic          last_pha;
  logic [DW-1:0] mul_res;

  assign idle     = (state_q == S_IDLE);
  assign div_done = (state_q == S_DONE);
  // A finishing divide owns the result bus, so the multiply pipe freezes for that cycle.
  assign adv      = mdu.dena & ~div_done;
  assign mul_acc  = (MUL_EN != 0) && mdu.dena && idle && (mdu.opc_of == OPC_MUL);
  assign div_acc  = (DIV_EN != 0) && mdu.dena && idle && (mdu.opc_of == OPC_DIV);

  // ------------------------------------------------------------------ multiply
  if (MUL_EN != 0) begin : g_mul
    logic                   s1_vld_q;
    logic                   s1_pha_q;
    logic                   s1_hi_q;
    logic signed [DW:0]     s1_a_q;
    logic signed [DW:0]     s1_b_q;
    logic signed [2*DW-1:0] prod;
    logic                   a_sgn;
    logic                   b_sgn;

    // mul/mulh treat both operands as signed, mulhsu only A, mulhu neither.
    assign a_sgn = (mdu.imm_of != 2'b11);
    assign b_sgn = ~mdu.imm_of[1];
    assign prod  = (2*DW)'(s1_a_q) * (2*DW)'(s1_b_q);

    always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
        s1_vld_q <= 1'b0;
      end else if (adv) begin
        s1_vld_q <= mul_acc;
      end
    end

    // NOTE: operand and product registers carry no reset; they are only ever
    // observed behind a reset-cleared valid bit, so resetting them buys nothing.
    always_ff @(posedge gclk) begin
      if (adv && mul_acc) begin
        s1_a_q   <= {a_sgn & mdu.opa_of[DW-1], mdu.opa_of};
        s1_b_q   <= {b_sgn & mdu.opb_of[DW-1], mdu.opb_of};
        s1_hi_q  <= (mdu.imm_of != 2'b00);
        s1_pha_q <= mdu.gpha;
      end
    end

    if (MUL_LAT == 1) begin : g_lat1
      assign last_vld = s1_vld_q;
      assign last_pha = s1_pha_q;
      assign mul_res  = s1_hi_q ? prod[2*DW-1:DW] : prod[DW-1:0];
    end else begin : g_latn
      localparam int N = MUL_LAT - 1;
      logic [N-1:0]    vld_q;
      logic [N-1:0]    pha_q;
      logic [N-1:0]    hi_q;
      logic [2*DW-1:0] prod_q [N];

      always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
          vld_q <= '0;
        end else if (adv) begin
          vld_q[0] <= s1_vld_q;
          for (int i = 1; i < N; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge gclk) begin
        if (adv) begin
          prod_q[0] <= prod;
          pha_q[0]  <= s1_pha_q;
          hi_q[0]   <= s1_hi_q;
          for (int i = 1; i < N; i++) begin
            prod_q[i] <= prod_q[i-1];
            pha_q[i]  <= pha_q[i-1];
            hi_q[i]   <= hi_q[i-1];
          end
        end
      end

      assign last_vld = vld_q[N-1];
      assign last_pha = pha_q[N-1];
      assign mul_res  = hi_q[N-1] ? prod_q[N-1][2*DW-1:DW] : prod_q[N-1][DW-1:0];
    end
  end else begin : g_nomul
    assign last_vld = 1'b0;
    assign last_pha = 1'b0;
    assign mul_res  = '0;
  end

  // ------------------------------------------------------------------- divide
  logic          div_sgn;
  logic [DW-1:0] a_abs;
  logic [DW-1:0] b_abs;
  logic [DW:0]   shifted;
  logic          ge;
  logic [DW-1:0] rem_nxt;

  // opa is the divisor and opb the dividend; signed ops divide magnitudes and fix the sign later.
  assign div_sgn = ~mdu.imm_of[1];
  assign a_abs   = (div_sgn & mdu.opa_of[DW-1]) ? -mdu.opa_of : mdu.opa_of;
  assign b_abs   = (div_sgn & mdu.opb_of[DW-1]) ? -mdu.opb_of : mdu.opb_of;

  assign shifted = {rem_q, quo_q[DW-1]};
  assign ge      = (shifted >= {1'b0, dsr_q});
  assign rem_nxt = ge ? DW'(shifted - {1'b0, dsr_q}) : shifted[DW-1:0];

  // NOTE: every register below updates with <= so all of them see the pre-edge
  // values; a blocking update here would let ITER consume its own result.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_q   <= S_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      div_pha_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_acc) begin
            state_q   <= S_SETUP;
            quo_q     <= b_abs;
            dsr_q     <= a_abs;
            neg_q     <= div_sgn & (mdu.opb_of[DW-1] ^ mdu.opa_of[DW-1]);
            div_pha_q <= mdu.gpha;
          end
        end
        S_SETUP: begin
          rem_q <= '0;
          cnt_q <= '0;
          dz_q  <= (dsr_q == '0);
          if (dsr_q == '0) begin
            quo_q   <= '0;
            state_q <= S_DONE;
          end else begin
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[DW-2:0], ge};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (neg_q) quo_q <= -quo_q;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  assign mul_fire      = last_vld & mdu.dena & ~div_done;
  assign mdu.mdu_vld   = div_done | mul_fire;
  assign mdu.mdu_mx    = div_done ? quo_q : (mul_fire ? mul_res : '0);
  assign mdu.mdu_pha   = div_done ? div_pha_q : (mul_fire & last_pha);
  assign mdu.mdu_dz    = div_done & dz_q;
  assign mdu.mdu_stall = (state_q == S_SETUP) | (state_q == S_ITER) | (state_q == S_FIX);

endmodule

// File: tb/tb_aemb2_mdu.sv
// Self-checking bench for aemb2_mdu: an arithmetic reference model compared every
// cycle, plus hand-computed literal results and latencies for directed vectors.
module tb_aemb2_mdu;

  localparam int DW      = 32;
  localparam int MUL_LAT = 2;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  always #5 gclk = ~gclk;

  aemb2_mdu_if #(.DW(DW)) bus ();

  aemb2_mdu #(
    .DW(DW), .MUL_EN(1), .MUL_LAT(MUL_LAT), .DIV_EN(1)
  ) dut (
    .gclk(gclk),
    .grst(grst),
    .mdu (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stall_seen = 0;

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct { logic [31:0] val; logic pha; int age; } mul_t;
  typedef struct { int cyc; logic [31:0] mx; logic pha; logic dz; } obs_t;

  mul_t        mq[$];
  obs_t        obs[$];
  bit          div_act = 0;
  int          div_age = 0;
  int          div_lat = 0;
  logic [31:0] div_val = '0;
  logic        div_pha = 1'b0;
  logic        div_dz  = 1'b0;

  function automatic logic [31:0] mul_ref(input logic [1:0] imm, input logic [31:0] a, b);
    logic signed [65:0] ea, eb, p;
    ea = (imm != 2'b11) ? $signed(a) : $signed({1'b0, a});
    eb = (!imm[1])      ? $signed(b) : $signed({1'b0, b});
    p  = ea * eb;
    return (imm == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_ref(input logic [1:0] imm, input logic [31:0] a, b,
                                          output logic dz);
    longint q;
    dz = (a == 32'd0);
    if (dz) return 32'd0;
    if (imm[1]) return b / a;
    q = longint'($signed(b)) / longint'($signed(a));
    return q[31:0];
  endfunction

  always @(negedge gclk) begin : cmp
    logic        e_vld, e_pha, e_dz, e_stall;
    logic [31:0] e_mx;
    bit          done_now, adv, idle;
    e_vld = 1'b0; e_pha = 1'b0; e_dz = 1'b0; e_stall = 1'b0; e_mx = '0;
    if (!grst) begin
      check("reset_outputs",
            {bus.mdu_vld, bus.mdu_pha, bus.mdu_dz, bus.mdu_stall, bus.mdu_mx}, 36'd0);
      mq.delete();
      div_act = 0;
    end else begin
      done_now = div_act && (div_age == div_lat);
      e_stall  = div_act && (div_age < div_lat);
      if (done_now) begin
        e_vld = 1'b1; e_mx = div_val; e_pha = div_pha; e_dz = div_dz;
      end else if (mq.size() > 0 && mq[0].age == MUL_LAT && bus.dena) begin
        e_vld = 1'b1; e_mx = mq[0].val; e_pha = mq[0].pha;
      end
      check("cycle_outputs",
            {bus.mdu_vld, bus.mdu_pha, bus.mdu_dz, bus.mdu_stall, bus.mdu_mx},
            {e_vld, e_pha, e_dz, e_stall, e_mx});
      if (bus.mdu_vld) obs.push_back('{cyc: cyc, mx: bus.mdu_mx, pha: bus.mdu_pha, dz: bus.mdu_dz});
      if (bus.mdu_stall) stall_seen++;

      adv  = bus.dena && !done_now;
      idle = !div_act;
      if (adv) begin
        foreach (mq[i]) mq[i].age++;
        if (mq.size() > 0 && mq[0].age > MUL_LAT) void'(mq.pop_front());
      end
      if (div_act) begin
        if (done_now) div_act = 0;
        else          div_age++;
      end
      if (idle && bus.dena) begin
        if (bus.opc_of == 6'h10) begin
          mq.push_back('{val: mul_ref(bus.imm_of, bus.opa_of, bus.opb_of), pha: bus.gpha, age: 1});
        end else if (bus.opc_of == 6'h12) begin
          div_val = div_ref(bus.imm_of, bus.opa_of, bus.opb_of, div_dz);
          div_pha = bus.gpha;
          div_act = 1;
          div_age = 1;
          div_lat = div_dz ? 2 : DW + 3;
        end
      end
    end
  end

  // --------------------------------------------------------------------- driver
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge gclk);
      #1;
    end
  endtask

  task automatic issue(input logic [5:0] opc, input logic [1:0] imm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic pha, output int acc);
    bus.opc_of = opc; bus.imm_of = imm; bus.opa_of = a; bus.opb_of = b;
    bus.gpha = pha; bus.dena = 1'b1;
    acc = cyc;
    tick(1);
    bus.opc_of = 6'h00; bus.gpha = 1'b0;
  endtask

  task automatic expect_obs(input string name, input int acc, input int lat,
                            input logic [31:0] mx, input logic pha, input logic dz);
    obs_t o;
    if (obs.size() == 0) begin
      check({name, "_present"}, 64'd0, 64'd1);
    end else begin
      o = obs.pop_front();
      check({name, "_latency"}, 64'(o.cyc - acc), 64'(lat));
      check({name, "_result"}, {o.pha, o.dz, o.mx}, {pha, dz, mx});
    end
  endtask

  initial begin : drv
    int a0, a1, b0, b1, b2, d0, z0, m0, r0, k0;
    bus.dena = 1'b0; bus.gpha = 1'b0; bus.opc_of = '0; bus.imm_of = '0;
    bus.opa_of = '0; bus.opb_of = '0;
    #1 grst = 1'b0;
    tick(3);
    check("reset_vld_stall", {bus.mdu_vld, bus.mdu_stall}, 2'b00);
    grst = 1'b1;
    bus.dena = 1'b1;
    tick(2);

    // mul 7 * -3, then the same with dena held low for three cycles mid-pipe
    issue(6'h10, 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1, a0);
    tick(4);
    expect_obs("mul", a0, 2, 32'hFFFF_FFEB, 1'b1, 1'b0);
    issue(6'h10, 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1, a1);
    bus.dena = 1'b0;
    tick(3);
    bus.dena = 1'b1;
    tick(4);
    expect_obs("mul_dena_hold", a1, 5, 32'hFFFF_FFEB, 1'b1, 1'b0);

    // high-word variants issued back to back
    issue(6'h10, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, b0);
    issue(6'h10, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, b1);
    issue(6'h10, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, b2);
    tick(4);
    expect_obs("mulhu", b0, 2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    expect_obs("mulh", b0, 3, 32'h0000_0000, 1'b1, 1'b0);
    expect_obs("mulhsu", b0, 4, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // unsigned divide 100 / 7
    stall_seen = 0;
    issue(6'h12, 2'b10, 32'd7, 32'd100, 1'b1, d0);
    bus.dena = 1'b0;
    tick(40);
    bus.dena = 1'b1;
    expect_obs("divu", d0, 35, 32'd14, 1'b1, 1'b0);
    check("divu_stall_cycles", 64'(stall_seen), 64'd34);

    // signed divides: -7 / 2 and the overflow case -2^31 / -1
    issue(6'h12, 2'b00, 32'd2, 32'hFFFF_FFF9, 1'b0, d0);
    bus.dena = 1'b0;
    tick(40);
    bus.dena = 1'b1;
    expect_obs("divs_neg", d0, 35, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(6'h12, 2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, d0);
    bus.dena = 1'b0;
    tick(40);
    bus.dena = 1'b1;
    expect_obs("divs_ovf", d0, 35, 32'h8000_0000, 1'b1, 1'b0);

    // divide by zero
    stall_seen = 0;
    issue(6'h12, 2'b00, 32'd0, 32'd5, 1'b1, z0);
    bus.dena = 1'b0;
    tick(4);
    bus.dena = 1'b1;
    expect_obs("div_zero", z0, 2, 32'd0, 1'b1, 1'b1);
    check("div_zero_stall_cycles", 64'(stall_seen), 64'd1);

    // multiply issued just before a divide is held until the divide result leaves
    issue(6'h10, 2'b00, 32'd5, 32'd6, 1'b1, m0);
    issue(6'h12, 2'b10, 32'd7, 32'd100, 1'b0, b1);
    bus.dena = 1'b0;
    tick(34);
    bus.dena = 1'b1;
    tick(3);
    expect_obs("div_priority", b1, 35, 32'd14, 1'b0, 1'b0);
    expect_obs("mul_held", m0, 37, 32'd30, 1'b1, 1'b0);

    // reset in the middle of a divide aborts it with no result
    issue(6'h12, 2'b10, 32'd7, 32'd100, 1'b1, r0);
    bus.dena = 1'b0;
    tick(10);
    grst = 1'b0;
    #1;
    check("abort_outputs", {bus.mdu_stall, bus.mdu_vld, bus.mdu_mx}, 34'd0);
    tick(2);
    grst = 1'b1;
    bus.dena = 1'b1;
    tick(40);
    check("abort_no_result", 64'(obs.size()), 64'd0);
    issue(6'h10, 2'b00, 32'd3, 32'd4, 1'b0, k0);
    tick(4);
    expect_obs("mul_after_reset", k0, 2, 32'd12, 1'b0, 1'b0);
    check("no_extra_results", 64'(obs.size()), 64'd0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
